// File: rtl/gpr_pkg.sv
// Shared constants for the multi-port GPR file and its read ports.
package gpr_pkg;
  localparam int unsigned GPR_DATA_W = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_ZERO   = 0;
endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: hardwired-zero check, write bypass and busy forward.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic              i_fwd_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic              i_st_busy,
  input  logic              i_wa_en,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [DATA_W-1:0] i_wa_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_mk_en,
  input  logic [ADDR_W-1:0] i_mk_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);
  logic w_zero;
  logic w_wa_hit;
  logic w_wb_hit;
  logic w_mk_hit;

  always_comb begin
    w_zero   = (i_addr == ADDR_W'(GPR_ZERO));
    w_wa_hit = (BYPASS != 0) && i_fwd_en && i_wa_en && (i_wa_addr == i_addr);
    w_wb_hit = (BYPASS != 0) && i_fwd_en && i_wb_en && (i_wb_addr == i_addr);
    w_mk_hit = i_mk_en && (i_mk_addr == i_addr);

    // Port A has priority over port B, matching the storage write order.
    o_data = i_st_data;
    if (w_wb_hit) o_data = i_wb_data;
    if (w_wa_hit) o_data = i_wa_data;
    if (w_zero)   o_data = '0;

    o_busy = i_st_busy;
    if (w_wb_hit && !w_mk_hit) o_busy = 1'b0;
    if (w_zero)                o_busy = 1'b0;
  end
endmodule

// File: rtl/gpr_mp.sv
// Multi-port GPR file with two write ports and a pending-load busy scoreboard.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W = GPR_DATA_W,
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned NUM_RD = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mk_en,
  input  logic [ADDR_W-1:0]        mk_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic              w_wa_we;
  logic              w_wb_we;
  logic              w_mk;
  logic              w_inc;
  logic              w_dec;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;

  always_comb begin
    w_wa_we = wa_en && (wa_addr != ADDR_W'(GPR_ZERO));
    w_wb_we = wb_en && (wb_addr != ADDR_W'(GPR_ZERO));
    w_mk    = mk_en && (mk_addr != ADDR_W'(GPR_ZERO)) && !flush;

    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wb_we) w_busy_nxt[wb_addr] = 1'b0;
      if (w_mk)    w_busy_nxt[mk_addr] = 1'b1;
    end

    // A clear on the index being marked is swallowed by the mark.
    w_inc = w_mk && !r_busy[mk_addr];
    w_dec = !flush && w_wb_we && r_busy[wb_addr] && !(w_mk && (mk_addr == wb_addr));

    w_cnt_nxt = r_busy_cnt;
    if (flush)               w_cnt_nxt = '0;
    else if (w_inc && !w_dec) w_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(1);
    else if (w_dec && !w_inc) w_cnt_nxt = r_busy_cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wb_we) r_mem[wb_addr] <= wb_data;
      if (w_wa_we) r_mem[wa_addr] <= wa_data;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    gpr_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .i_fwd_en  (rst),
      .i_addr    (w_addr),
      .i_st_data (r_mem[w_addr]),
      .i_st_busy (r_busy[w_addr]),
      .i_wa_en   (wa_en),
      .i_wa_addr (wa_addr),
      .i_wa_data (wa_data),
      .i_wb_en   (wb_en),
      .i_wb_addr (wb_addr),
      .i_wb_data (wb_data),
      .i_mk_en   (mk_en),
      .i_mk_addr (mk_addr),
      .o_data    (rd_data[k*DATA_W +: DATA_W]),
      .o_busy    (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: a BYPASS=1 and a BYPASS=0 build driven in lockstep.
module tb_gpr_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] d1, d0;
  logic [NR-1:0]    b1, b0;
  logic [AW:0]      c1, c0;
  logic             wa_en, wb_en, mk_en, flush;
  logic [AW-1:0]    wa_addr, wb_addr, mk_addr;
  logic [DW-1:0]    wa_data, wb_data;

  gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(d1), .rd_busy(b1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mk_en(mk_en), .mk_addr(mk_addr), .flush(flush), .busy_cnt(c1));

  gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(d0), .rd_busy(b0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mk_en(mk_en), .mk_addr(mk_addr), .flush(flush), .busy_cnt(c0));

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];

  typedef struct {
    logic wa_en; logic [AW-1:0] wa_addr; logic [DW-1:0] wa_data;
    logic wb_en; logic [AW-1:0] wb_addr; logic [DW-1:0] wb_data;
    logic mk_en; logic [AW-1:0] mk_addr; logic flush;
    logic [AW-1:0] ra;
    logic [DW-1:0] d_byp; logic b_byp;
    logic [DW-1:0] d_nb;  logic b_nb;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; mk_en = 0; flush = 0;
    wa_addr = '0; wb_addr = '0; mk_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 0;
    end
  endtask

  // Effect of one rising edge on the architectural state.
  task automatic model_edge();
    if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
    if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end else begin
      if (wb_en) m_busy[wb_addr] = 0;
      if (mk_en) m_busy[mk_addr] = 1;
    end
    m_busy[0] = 0;
  endtask

  function automatic logic [DW-1:0] m_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && wa_en && int'(wa_addr) == a) return wa_data;
    if (byp && wb_en && int'(wb_addr) == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic bit m_rb(input int a, input bit byp);
    if (a == 0) return 0;
    if (byp && wb_en && int'(wb_addr) == a && !(mk_en && int'(mk_addr) == a)) return 0;
    return m_busy[a];
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic check_model(input string tag);
    for (int k = 0; k < NR; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("%s byp_data[%0d] a=%0d", tag, k, a), d1[k*DW +: DW], m_rd(a, 1));
      chk($sformatf("%s byp_busy[%0d] a=%0d", tag, k, a), DW'(b1[k]), DW'(m_rb(a, 1)));
      chk($sformatf("%s nb_data[%0d] a=%0d", tag, k, a), d0[k*DW +: DW], m_rd(a, 0));
      chk($sformatf("%s nb_busy[%0d] a=%0d", tag, k, a), DW'(b0[k]), DW'(m_rb(a, 0)));
    end
    chk($sformatf("%s byp_cnt", tag), DW'(c1), DW'(m_cnt()));
    chk($sformatf("%s nb_cnt", tag), DW'(c0), DW'(m_cnt()));
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s byp_data[%0d]", tag, k), d1[k*DW +: DW], '0);
      chk($sformatf("%s byp_busy[%0d]", tag, k), DW'(b1[k]), '0);
      chk($sformatf("%s nb_data[%0d]", tag, k), d0[k*DW +: DW], '0);
      chk($sformatf("%s nb_busy[%0d]", tag, k), DW'(b0[k]), '0);
    end
    chk({tag, " byp_cnt"}, DW'(c1), '0);
    chk({tag, " nb_cnt"}, DW'(c0), '0);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    //         wa_en addr data          wb_en addr data          mk addr fl  ra   d_byp         b  d_nb          b  cnt
    tbl[0]  = '{1, 7,  32'h11111111, 1, 7,  32'h22222222, 0, 0, 0, 7,  32'h11111111, 0, 32'h0,        0, 0};
    tbl[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 7,  32'h11111111, 0, 32'h11111111, 0, 0};
    tbl[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 5, 0, 5,  32'h0,        0, 32'h0,        0, 0};
    tbl[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 5,  32'h0,        1, 32'h0,        1, 1};
    tbl[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 5,  32'h0,        1, 32'h0,        1, 1};
    tbl[5]  = '{0, 0,  32'h0,        1, 5,  32'hCAFEF00D, 0, 0, 0, 5,  32'hCAFEF00D, 0, 32'h0,        1, 1};
    tbl[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 5,  32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0};
    tbl[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9, 0, 9,  32'h0,        0, 32'h0,        0, 0};
    tbl[8]  = '{0, 0,  32'h0,        1, 9,  32'h00000099, 1, 9, 0, 9,  32'h00000099, 1, 32'h0,        1, 1};
    tbl[9]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 9,  32'h00000099, 1, 32'h00000099, 1, 1};
    tbl[10] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 3, 1, 3,  32'h0,        0, 32'h0,        0, 1};
    tbl[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 9,  32'h00000099, 0, 32'h00000099, 0, 0};
    tbl[12] = '{1, 0,  32'hFFFFFFFF, 1, 0,  32'hFFFFFFFF, 1, 0, 0, 0,  32'h0,        0, 32'h0,        0, 0};
    tbl[13] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 0};
    tbl[14] = '{1, 12, 32'h0000ABCD, 0, 0,  32'h0,        0, 0, 0, 12, 32'h0000ABCD, 0, 32'h0,        0, 0};
    tbl[15] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 12, 32'h0000ABCD, 0, 32'h0000ABCD, 0, 0};

    idle();
    rd_addr = {5'd3, 5'd2, 5'd1};
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_initial");
    rst = 1'b1;

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data;
      wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
      mk_en = v.mk_en; mk_addr = v.mk_addr; flush = v.flush;
      rd_addr = {NR{v.ra}};
      #1;
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("vec%0d byp_data[%0d]", i, k), d1[k*DW +: DW], v.d_byp);
        chk($sformatf("vec%0d byp_busy[%0d]", i, k), DW'(b1[k]), DW'(v.b_byp));
        chk($sformatf("vec%0d nb_data[%0d]", i, k), d0[k*DW +: DW], v.d_nb);
        chk($sformatf("vec%0d nb_busy[%0d]", i, k), DW'(b0[k]), DW'(v.b_nb));
      end
      chk($sformatf("vec%0d byp_cnt", i), DW'(c1), DW'(v.cnt));
      chk($sformatf("vec%0d nb_cnt", i), DW'(c0), DW'(v.cnt));
      edge_step();
    end

    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] pick [4];
      wa_en = ($urandom_range(0, 2) != 0);
      wb_en = ($urandom_range(0, 2) != 0);
      mk_en = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      wa_addr = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wb_addr = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      mk_addr = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      wa_data = $urandom;
      wb_data = $urandom;
      pick[0] = wa_addr; pick[1] = wb_addr; pick[2] = mk_addr;
      for (int k = 0; k < NR; k++) begin
        pick[3] = AW'($urandom_range(0, 31));
        rd_addr[k*AW +: AW] = pick[$urandom_range(0, 3)];
      end
      #1;
      check_model($sformatf("rand%0d", n));
      edge_step();
    end

    idle();
    for (int r = 1; r < DEPTH; r++) begin
      wa_en = 1; wa_addr = AW'(r); wa_data = 32'hA5000000 | DW'(r);
      mk_en = (r % 3 == 0); mk_addr = AW'(r);
      edge_step();
    end
    idle();
    rd_addr = {5'd31, 5'd17, 5'd3};
    #1;
    check_model("pre_reset");

    // Drop reset mid-cycle while a write is presented to a read address.
    #2;
    rst = 1'b0;
    wa_en = 1; wa_addr = 5'd17; wa_data = 32'hDEADBEEF;
    wb_en = 1; wb_addr = 5'd3;  wb_data = 32'hBEEFDEAD;
    mk_en = 1; mk_addr = 5'd31;
    #1;
    check_all_zero("reset_async");
    for (int r = 1; r < DEPTH; r += 3) begin
      rd_addr = {AW'(r), AW'((r + 1) % DEPTH), AW'((r + 2) % DEPTH)};
      #1;
      check_all_zero($sformatf("reset_sweep%0d", r));
    end
    @(posedge clk);
    #1;
    check_all_zero("reset_held_edge");
    idle();
    model_clear();
    rst = 1'b1;
    rd_addr = {5'd31, 5'd17, 5'd3};
    #1;
    check_model("post_reset");
    wa_en = 1; wa_addr = 5'd17; wa_data = 32'h12345678;
    #1;
    check_model("first_write_same");
    edge_step();
    idle();
    #1;
    check_model("first_write_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
